// File: rtl/booth_controller.sv
// booth_controller: control FSM for the radix-2 Booth multiplier datapath.
// Sequences load, add/subtract and shift steps and captures the product.
module booth_controller #(
    parameter int N_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  q0,
    input  logic                  qm1,
    input  logic                  eqz,
    input  logic [2*N_BITS-1:0]   data_in,
    output logic                  LdA,
    output logic                  LdQ,
    output logic                  LdM,
    output logic                  LdCount,
    output logic                  clrA,
    output logic                  clrQ,
    output logic                  clrM,
    output logic                  clrff,
    output logic                  sftA,
    output logic                  sftQ,
    output logic                  sftDff,
    output logic                  add_sub,
    output logic                  EnableALU,
    output logic                  decr,
    output logic                  busy,
    output logic                  done,
    output logic [2*N_BITS-1:0]   product
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ARITH = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Control word layout:
    // {LdA,LdQ,LdM,LdCount,clrA,clrff,sftA,sftQ,sftDff,EnableALU,decr,busy,done}
    localparam logic [12:0] C_IDLE  = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] C_LOAD  = 13'b0_1_1_1_1_1_0_0_0_0_0_1_0;
    localparam logic [12:0] C_CHECK = 13'b0_0_0_0_0_0_0_0_0_0_0_1_0;
    localparam logic [12:0] C_ARITH = 13'b1_0_0_0_0_0_0_0_0_1_0_1_0;
    localparam logic [12:0] C_SHIFT = 13'b0_0_0_0_0_0_1_1_1_0_1_1_0;
    localparam logic [12:0] C_DONE  = 13'b0_0_0_0_0_0_0_0_0_0_0_1_1;

    state_t                r_state;
    logic                  r_op;
    logic [12:0]           r_ctl;
    logic [2*N_BITS-1:0]   r_product;
    logic                  w_run;

    // State, op, product and the registered control word for the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= 1'b0;
            r_product <= '0;
            r_ctl     <= C_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_ctl   <= C_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                        r_ctl   <= C_IDLE;
                    end
                end
                S_LOAD: begin
                    r_state <= S_CHECK;
                    r_ctl   <= C_CHECK;
                end
                S_CHECK: begin
                    if (eqz) begin
                        r_state   <= S_DONE;
                        r_ctl     <= C_DONE;
                        r_product <= data_in;
                    end else begin
                        case ({q0, qm1})
                            2'b10: begin
                                r_op    <= 1'b0;
                                r_state <= S_ARITH;
                                r_ctl   <= C_ARITH;
                            end
                            2'b01: begin
                                r_op    <= 1'b1;
                                r_state <= S_ARITH;
                                r_ctl   <= C_ARITH;
                            end
                            default: begin
                                r_state <= S_SHIFT;
                                r_ctl   <= C_SHIFT;
                            end
                        endcase
                    end
                end
                S_ARITH: begin
                    r_state <= S_SHIFT;
                    r_ctl   <= C_SHIFT;
                end
                S_SHIFT: begin
                    r_state <= S_CHECK;
                    r_ctl   <= C_CHECK;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ctl   <= C_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctl   <= C_IDLE;
                end
            endcase
        end
    end

    // Reset forces the clears on and masks everything else
    assign w_run     = ~rst;
    assign LdA       = r_ctl[12] & w_run;
    assign LdQ       = r_ctl[11] & w_run;
    assign LdM       = r_ctl[10] & w_run;
    assign LdCount   = r_ctl[9]  & w_run;
    assign clrA      = r_ctl[8]  | rst;
    assign clrff     = r_ctl[7]  | rst;
    assign sftA      = r_ctl[6]  & w_run;
    assign sftQ      = r_ctl[5]  & w_run;
    assign sftDff    = r_ctl[4]  & w_run;
    assign EnableALU = r_ctl[3]  & w_run;
    assign decr      = r_ctl[2]  & w_run;
    assign busy      = r_ctl[1]  & w_run;
    assign done      = r_ctl[0]  & w_run;
    assign clrQ      = rst;
    assign clrM      = rst;
    assign add_sub   = r_op & w_run;
    assign product   = r_product;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: drives the Booth controller against a behavioural
// datapath and a schedule-level reference model, checking every cycle.
module tb_booth_controller;

    localparam int N = 8;
    localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_SUB = 3,
                   P_ADD = 4, P_SHIFT = 5, P_DONE = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic q0, qm1, eqz;
    logic [2*N-1:0] data_in;
    logic LdA, LdQ, LdM, LdCount, clrA, clrQ, clrM, clrff;
    logic sftA, sftQ, sftDff, add_sub, EnableALU, decr, busy, done;
    logic [2*N-1:0] product;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_controller #(.N_BITS(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .q0(q0), .qm1(qm1), .eqz(eqz), .data_in(data_in),
        .LdA(LdA), .LdQ(LdQ), .LdM(LdM), .LdCount(LdCount),
        .clrA(clrA), .clrQ(clrQ), .clrM(clrM), .clrff(clrff),
        .sftA(sftA), .sftQ(sftQ), .sftDff(sftDff),
        .add_sub(add_sub), .EnableALU(EnableALU), .decr(decr),
        .busy(busy), .done(done), .product(product)
    );

    // Behavioural Booth datapath (A one bit wider to absorb -M overflow)
    logic [7:0] opM = 8'h00;
    logic [7:0] opQ = 8'h00;
    logic [8:0] dA = '0;
    logic [7:0] dQ = '0;
    logic [7:0] dM = '0;
    logic       dff = 1'b0;
    logic [4:0] dCnt = '0;

    always @(posedge clk) begin
        if (clrA) dA <= '0;
        if (clrQ) dQ <= '0;
        if (clrM) dM <= '0;
        if (clrff) dff <= 1'b0;
        if (LdM) dM <= opM;
        if (LdQ) dQ <= opQ;
        if (LdCount) dCnt <= 5'(N);
        if (LdA && EnableALU)
            dA <= add_sub ? dA + {dM[7], dM} : dA - {dM[7], dM};
        if (sftA) {dA, dQ, dff} <= {dA[8], dA, dQ};
        if (decr) dCnt <= dCnt - 5'd1;
    end

    assign q0 = dQ[0];
    assign qm1 = dff;
    assign eqz = (dCnt == 5'd0);
    assign data_in = {dA[7:0], dQ};

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a list of phases derived from the multiplier bits
    int ph = P_IDLE;
    int sched[$];
    logic eop = 1'b0;
    logic [15:0] eprod = '0;
    logic [15:0] pend = '0;
    bit mvalid = 1'b0;

    function automatic logic [15:0] smul(input logic [7:0] m, input logic [7:0] q);
        logic signed [15:0] a, b, p;
        a = $signed({{8{m[7]}}, m});
        b = $signed({{8{q[7]}}, q});
        p = a * b;
        return p;
    endfunction

    function automatic int nk(input logic [7:0] q);
        logic [7:0] d;
        d = q ^ {q[6:0], 1'b0};
        return $countones(d);
    endfunction

    task automatic build(input logic [7:0] m, input logic [7:0] q);
        bit prev;
        sched.delete();
        sched.push_back(P_LOAD);
        prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            sched.push_back(P_CHECK);
            if (q[i] && !prev) sched.push_back(P_SUB);
            else if (!q[i] && prev) sched.push_back(P_ADD);
            sched.push_back(P_SHIFT);
            prev = q[i];
        end
        sched.push_back(P_CHECK);
        sched.push_back(P_DONE);
        pend = smul(m, q);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ph = P_IDLE;
            sched.delete();
            eop = 1'b0;
            eprod = '0;
            mvalid = 1'b1;
        end else if (ph == P_IDLE) begin
            if (start) begin
                build(opM, opQ);
                ph = sched.pop_front();
            end
        end else begin
            ph = (sched.size() > 0) ? sched.pop_front() : P_IDLE;
            if (ph == P_SUB) eop = 1'b0;
            if (ph == P_ADD) eop = 1'b1;
            if (ph == P_DONE) eprod = pend;
        end
    end

    // {LdA,LdQ,LdM,LdCount,clrA,clrQ,clrM,clrff,sftA,sftQ,sftDff,En,decr,busy,done}
    function automatic logic [14:0] exp_ctl(input int p, input logic r);
        if (r) return 15'b0000_1111_000_0000;
        case (p)
            P_LOAD:  return 15'b0111_1001_000_0010;
            P_CHECK: return 15'b0000_0000_000_0010;
            P_SUB,
            P_ADD:   return 15'b1000_0000_000_1010;
            P_SHIFT: return 15'b0000_0000_111_0110;
            P_DONE:  return 15'b0000_0000_000_0011;
            default: return 15'b0000_0000_000_0000;
        endcase
    endfunction

    int ndone = 0;
    bit opq[$];

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            check("ctl", 32'({LdA, LdQ, LdM, LdCount, clrA, clrQ, clrM, clrff,
                         sftA, sftQ, sftDff, EnableALU, decr, busy, done}),
                  32'(exp_ctl(ph, rst)));
            if (!rst) begin
                check("add_sub", 32'(add_sub), 32'(eop));
                check("product", 32'(product), 32'(eprod));
            end
            if (done) ndone++;
            if (!rst && EnableALU) opq.push_back(add_sub);
        end
    end

    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          input bit noise, output int lat,
                          output logic [15:0] prod);
        opM = m;
        opQ = q;
        opq.delete();
        lat = -1;
        prod = 'x;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                prod = product;
                break;
            end
            if (noise) start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL timeout got=none exp=done m=%h q=%h", m, q);
        end
    endtask

    int lat;
    int gap;
    int d0;
    logic [15:0] pr;
    logic [7:0] rm, rq;

    initial begin
        // Reset then idle
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_prod", 32'(product), 32'h0000);

        run_op(8'd3, 8'hFE, 1'b0, lat, pr);
        check("m3q-2_prod", 32'(pr), 32'hFFFA);
        check("m3q-2_lat", 32'(lat), 32'd20);
        check("m3q-2_nops", 32'(opq.size()), 32'd1);

        run_op(8'd7, 8'd5, 1'b0, lat, pr);
        check("m7q5_prod", 32'(pr), 32'h0023);
        check("m7q5_lat", 32'(lat), 32'd23);
        check("m7q5_nops", 32'(opq.size()), 32'd4);
        if (opq.size() == 4)
            check("m7q5_order", 32'({opq[0], opq[1], opq[2], opq[3]}),
                  32'b0101);

        run_op(8'h80, 8'h80, 1'b0, lat, pr);
        check("m80q80_prod", 32'(pr), 32'h4000);
        check("m80q80_lat", 32'(lat), 32'd20);

        // Max transitions, then start held high for a back-to-back op
        opM = 8'd1;
        opQ = 8'h55;
        opq.delete();
        @(posedge clk);
        #1 start = 1'b1;
        lat = -1;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                pr = product;
                break;
            end
        end
        check("m1q55_prod", 32'(pr), 32'h0055);
        check("m1q55_lat", 32'(lat), 32'd27);
        check("m1q55_nops", 32'(opq.size()), 32'd8);
        gap = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (busy) break;
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'd1);
        d0 = ndone;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        check("b2b_lat", 32'(lat), 32'd27);
        repeat (5) @(negedge clk);
        check("b2b_ndone", 32'(ndone - d0), 32'd1);
        check("b2b_idle", 32'(busy), 32'd0);

        // Abort mid-operation
        opM = 8'd7;
        opQ = 8'd5;
        d0 = ndone;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_prod", 32'(product), 32'h0000);
        repeat (30) @(negedge clk);
        check("abort_nodone", 32'(ndone - d0), 32'd0);

        run_op(8'd2, 8'd3, 1'b0, lat, pr);
        check("m2q3_prod", 32'(pr), 32'h0006);
        check("m2q3_lat", 32'(lat), 32'd21);

        // Randomized operands with start noise while busy
        for (int t = 0; t < 25; t++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            run_op(rm, rq, 1'b1, lat, pr);
            check("rnd_prod", 32'(pr), 32'(smul(rm, rq)));
            check("rnd_lat", 32'(lat), 32'(19 + nk(rq)));
            check("rnd_nops", 32'(opq.size()), 32'(nk(rq)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
